// File: rtl/osd_pkg.sv
// Shared constants and types for the OSD command initiator.
package osd_pkg;

  localparam logic [7:0] OSD_CMD_DISABLE = 8'h40;
  localparam logic [7:0] OSD_CMD_ENABLE  = 8'h41;
  localparam logic [7:0] OSD_CMD_WRITE   = 8'h20;
  localparam logic [7:0] OSD_CMD_PALETTE = 8'h80;
  localparam int         OSD_MAX_WORDS   = 5120;
  localparam int         OSD_AW          = 13;

  // IDLE: waiting for a request; LO/HI: strobe phases of the current slot;
  // GAP: io_osd held low so the receiver sees the frame close.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_GAP  = 2'd3
  } osd_state_e;

  // Requested word count limited to what the receiver's buffer can hold.
  function automatic logic [OSD_AW-1:0] clamp_len(input logic [OSD_AW-1:0] l);
    return (l > OSD_AW'(OSD_MAX_WORDS)) ? OSD_AW'(OSD_MAX_WORDS) : l;
  endfunction

endpackage

// File: rtl/osd_strobe_timer.sv
// Down-counting phase timer. The controller loads (phase length - 1) on the
// edge that enters a phase; `last` is high during the final cycle of that
// phase and `near` during the cycle before it.
module osd_strobe_timer #(
  parameter int W = 16
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last,
  output logic         near
);

  logic [W-1:0] cnt;

  // Count down to zero and hold there until the next load.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == '0);
  assign near = (cnt == W'(1));

endmodule

// File: rtl/osd_cmd_tx.sv
// OSD command bus initiator: frames one command byte plus up to 5120 data
// words from a synchronous word buffer onto io_osd / io_strobe / io_din,
// then holds io_osd low for GAP cycles before accepting the next request.
module osd_cmd_tx
  import osd_pkg::*;
#(
  parameter int STB_HI = 2,
  parameter int STB_LO = 2,
  parameter int GAP    = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_cmd,
  input  logic [OSD_AW-1:0] req_len,
  output logic [OSD_AW-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic              io_osd,
  output logic              io_strobe,
  output logic [15:0]       io_din
);

  if (STB_HI < 1) begin : g_bad_stb_hi
    $error("osd_cmd_tx: STB_HI must be >= 1");
  end
  if (STB_LO < 1) begin : g_bad_stb_lo
    $error("osd_cmd_tx: STB_LO must be >= 1");
  end
  if (GAP < 1) begin : g_bad_gap
    $error("osd_cmd_tx: GAP must be >= 1");
  end

  localparam int TW = 16;
  localparam logic [TW-1:0] LO_N  = TW'(STB_LO - 1);
  localparam logic [TW-1:0] HI_N  = TW'(STB_HI - 1);
  localparam logic [TW-1:0] GAP_N = TW'(GAP - 1);

  osd_state_e        state;
  logic [OSD_AW-1:0] len;
  logic [OSD_AW-1:0] k;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_last;
  logic              tmr_near;

  // Handshake: a request moves when req_valid & req_ready are both high at a
  // clock edge. req_ready is high only in IDLE and is registered, so it rises
  // one cycle after reset releases and one cycle after the gap ends.
  wire accept = (state == ST_IDLE) && req_ready && req_valid;

  // Phase timer (re)load on every phase entry.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          tmr_val  = LO_N;
        end
      end
      ST_LO: begin
        if (tmr_last) begin
          tmr_load = 1'b1;
          tmr_val  = HI_N;
        end
      end
      ST_HI: begin
        if (tmr_last) begin
          tmr_load = 1'b1;
          tmr_val  = (k == len) ? GAP_N : LO_N;
        end
      end
      default: begin
      end
    endcase
  end

  osd_strobe_timer #(
    .W(TW)
  ) u_timer (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last),
    .near     (tmr_near)
  );

  // Frame sequencer with registered bus outputs.
  // io_din is loaded only on the edge entering a slot's LO phase, so it is
  // stable for the whole strobe-high window. The buffer address for slot k+1
  // is issued when slot k enters HI; with a one-cycle buffer latency the data
  // has landed by the LO entry of slot k+1 whenever STB_HI >= 2.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      len       <= '0;
      k         <= '0;
      rd_addr   <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      io_osd    <= 1'b0;
      io_strobe <= 1'b0;
      io_din    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            len       <= clamp_len(req_len);
            k         <= '0;
            rd_addr   <= '0;
            io_osd    <= 1'b1;
            io_din    <= {8'h00, req_cmd};
            state     <= ST_LO;
          end
        end
        ST_LO: begin
          if (tmr_last) begin
            io_strobe <= 1'b1;
            if (k < len) begin
              rd_addr <= k;
            end
            state <= ST_HI;
          end
        end
        ST_HI: begin
          if (tmr_last) begin
            io_strobe <= 1'b0;
            if (k == len) begin
              io_osd <= 1'b0;
              io_din <= '0;
              done   <= (GAP == 1);
              state  <= ST_GAP;
            end else begin
              k      <= k + OSD_AW'(1);
              io_din <= rd_data;
              state  <= ST_LO;
            end
          end
        end
        ST_GAP: begin
          if (tmr_near) begin
            done <= 1'b1;
          end
          if (tmr_last) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osd_cmd_tx.sv
// Bench for osd_cmd_tx at default timing (STB_LO=2, STB_HI=2, GAP=4).
module tb_osd_cmd_tx;

  localparam int STB_LO_C = 2;
  localparam int STB_HI_C = 2;
  localparam int GAP_C    = 4;
  localparam int SLOT_C   = STB_LO_C + STB_HI_C;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_cmd = '0;
  logic [12:0] req_len = '0;
  logic [12:0] rd_addr;
  logic [15:0] rd_data = '0;
  logic        busy;
  logic        done;
  logic        io_osd;
  logic        io_strobe;
  logic [15:0] io_din;

  osd_cmd_tx dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_len   (req_len),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .io_osd    (io_osd),
    .io_strobe (io_strobe),
    .io_din    (io_din)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- word buffer model (one-cycle read latency) ----------------
  logic [15:0] mem [0:8191];
  always @(posedge clk_sys) rd_data <= mem[rd_addr];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // ---------------- scoreboard / receiver monitor ----------------
  logic [15:0] exp_q[$];
  int          exp_done = 0;
  int          done_cnt = 0;
  int          frame_strobes = 0;
  int          low_run = 0;
  int          last_low_run = 0;
  int          rx_idx = 0;
  logic [15:0] rx_cmd = '0;
  logic [15:0] rx_pal [0:15];
  logic [15:0] held_din = '0;
  logic        prev_strobe = 1'b0;
  logic        prev_osd = 1'b0;

  always @(negedge clk_sys) begin
    if (reset) begin
      prev_strobe = 1'b0;
      prev_osd    = 1'b0;
      low_run     = 0;
    end else begin
      if (io_osd && !prev_osd) begin
        last_low_run  = low_run;
        frame_strobes = 0;
        rx_idx        = 0;
      end
      if (!io_osd) low_run++;
      else low_run = 0;
      if (io_strobe && !prev_strobe) begin
        frame_strobes++;
        held_din = io_din;
        check("word_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("word", 32'(io_din), 32'(exp_q.pop_front()));
        if (rx_idx == 0) rx_cmd = io_din;
        else if (rx_idx <= 16) rx_pal[rx_idx-1] = io_din;
        rx_idx++;
      end else if (io_strobe && prev_strobe) begin
        check("din_stable", 32'(io_din), 32'(held_din));
      end
      if (done) done_cnt++;
      prev_strobe = io_strobe;
      prev_osd    = io_osd;
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc = 0;

  // Offer a request, wait for acceptance, push the expected strobed words.
  task automatic send(input logic [7:0] c, input logic [12:0] l, input bit hold);
    int n;
    bit ok;
    req_cmd   = c;
    req_len   = l;
    req_valid = 1'b1;
    ok = 1'b0;
    n  = (int'(l) > 5120) ? 5120 : int'(l);
    for (int t = 0; t < 200; t++) begin
      if (req_ready) begin
        @(posedge clk_sys);
        ok = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
    check("accept", 32'(ok), 32'd1);
    #1;
    acc_cyc = cyc;
    if (!hold) req_valid = 1'b0;
    if (ok) begin
      exp_q.push_back({8'h00, c});
      for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
      exp_done++;
    end
  endtask

  // Cycle-by-cycle check of a frame, rel=1 being the first cycle after acceptance.
  task automatic check_frame(input int len_c, input logic [7:0] c);
    int f, rel_end, s, ph, ea;
    f = (len_c + 1) * SLOT_C;
    rel_end = f + GAP_C + 1;
    for (int rel = 1; rel <= rel_end; rel++) begin
      @(negedge clk_sys);
      s  = (rel - 1) / SLOT_C;
      ph = (rel - 1) % SLOT_C;
      check("io_osd",    32'(io_osd),    32'(rel <= f));
      check("io_strobe", 32'(io_strobe), 32'(rel <= f && ph >= STB_LO_C));
      check("done",      32'(done),      32'(rel == f + GAP_C));
      check("req_ready", 32'(req_ready), 32'(rel == rel_end));
      check("busy",      32'(busy),      32'(rel < rel_end));
      if (rel <= SLOT_C) check("din_cmd", 32'(io_din), 32'({8'h00, c}));
      if (rel > f) check("din_idle", 32'(io_din), 32'd0);
      if (rel <= f) ea = (ph >= STB_LO_C && s < len_c) ? s : ((s == 0) ? 0 : s - 1);
      else ea = (len_c == 0) ? 0 : len_c - 1;
      check("rd_addr", 32'(rd_addr), 32'(ea));
    end
  endtask

  // ---------------- main sequence ----------------
  int acc1, acc2, dc0;

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom_range(0, 65535));

    // reset state
    repeat (4) @(negedge clk_sys);
    check("rst_osd",    32'(io_osd),    32'd0);
    check("rst_strobe", 32'(io_strobe), 32'd0);
    check("rst_din",    32'(io_din),    32'd0);
    check("rst_rdaddr", 32'(rd_addr),   32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_ready",  32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk_sys);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // command-only enable frame
    send(8'h41, 13'd0, 1'b0);
    check_frame(0, 8'h41);

    // short row write
    mem[0] = 16'h0101; mem[1] = 16'h0202; mem[2] = 16'h03FF;
    @(negedge clk_sys);
    send(8'h20, 13'd3, 1'b0);
    check_frame(3, 8'h20);

    // palette load into the receiver model
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom_range(0, 65535));
    @(negedge clk_sys);
    send(8'h80, 13'd8, 1'b0);
    check_frame(8, 8'h80);
    check("pal_cmd", 32'(rx_cmd), 32'h0080);
    check("pal_strobes", 32'(frame_strobes), 32'd9);
    for (int i = 0; i < 8; i++) check("pal_entry", 32'(rx_pal[i]), 32'(mem[i]));

    // back-to-back with req_valid held high
    @(negedge clk_sys);
    send(8'h41, 13'd0, 1'b1);
    acc1 = acc_cyc;
    send(8'h40, 13'd0, 1'b0);
    acc2 = acc_cyc;
    check("b2b_accept_gap", 32'(acc2 - acc1), 32'(SLOT_C + GAP_C + 1));
    check_frame(0, 8'h40);
    check("b2b_low_ge", 32'(last_low_run >= GAP_C + 1), 32'd1);
    check("b2b_low_run", 32'(last_low_run), 32'(GAP_C + 1));

    // reset during slot 2 of a len-3 write
    mem[0] = 16'h0101; mem[1] = 16'h0202; mem[2] = 16'h03FF;
    @(negedge clk_sys);
    send(8'h20, 13'd3, 1'b0);
    repeat (2 * SLOT_C + 1) @(negedge clk_sys);
    dc0 = done_cnt;
    reset = 1'b1;
    @(negedge clk_sys);
    check("mid_rst_osd",    32'(io_osd),    32'd0);
    check("mid_rst_strobe", 32'(io_strobe), 32'd0);
    check("mid_rst_din",    32'(io_din),    32'd0);
    check("mid_rst_rdaddr", 32'(rd_addr),   32'd0);
    check("mid_rst_done",   32'(done),      32'd0);
    check("mid_rst_busy",   32'(busy),      32'd0);
    check("mid_rst_ready",  32'(req_ready), 32'd0);
    check("mid_rst_unsent", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    exp_done--;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    check("mid_rst_no_done", 32'(done_cnt), 32'(dc0));
    check("mid_rst_ready_back", 32'(req_ready), 32'd1);
    send(8'h41, 13'd0, 1'b0);
    check_frame(0, 8'h41);

    // oversize request clamps to 5120 data words
    for (int i = 0; i < 5120; i++) mem[i] = 16'($urandom_range(0, 65535));
    @(negedge clk_sys);
    dc0 = done_cnt;
    send(8'h20, 13'd6000, 1'b0);
    for (int t = 0; t < 30000; t++) begin
      @(negedge clk_sys);
      if (done) break;
    end
    check("big_done_seen", 32'(done), 32'd1);
    repeat (3) @(negedge clk_sys);
    check("big_strobes", 32'(frame_strobes), 32'd5121);
    check("big_last_addr", 32'(rd_addr), 32'd5119);
    check("big_single_done", 32'(done_cnt - dc0), 32'd1);
    check("big_sb_empty", 32'(exp_q.size()), 32'd0);

    // final scoreboard state
    check("done_total", 32'(done_cnt), 32'(exp_done));
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
